feature_window_engine: RTL and testbench
========================================

// Module: feature_window_engine
// PURPOSE
//  Parametrised market-feature extractor: DW-bit price/volume, 2^RING_LOG2-deep rings, 2^WIN_LOG2-cycle windows.
//  Emits an 8x8-bit feature frame per window to the ML inference engine over valid/ready.
//  Adds frame hold/backpressure, overrun flag, soft clear, signed trend and volume-level features.
// PARAMETERS
//  DW        12   price/volume width, 8..16
//  RING_LOG2 2    log2 ring depth, 1..4
//  WIN_LOG2  8    log2 window length in clk cycles, 4..12
//  EMA_SH    3    EMA shift for MAD and slow-change accumulators, 1..4
//  RST_LEVEL 100  reset/clear value of every ring entry and cur_vol
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       sample strobe; state updates only when high
//  input_type   in   2       00 price, 01 volume, 10 buy, 11 sell
//  price_data   in   DW      price sample
//  volume_data  in   DW      volume sample
//  clear        in   1       sync soft clear of internal state (priority over samples)
//  feat_valid   out  1       frame available
//  feat_ready   in   1       consumer accepts frame
//  features     out  64      byte k = feature k, bits [8k+7:8k]
//  overrun      out  1       1-cycle pulse: frame dropped, slot occupied
// BEHAVIOUR
//  Reset: feat_valid=0, features=0, overrun=0. Rings and sums at RST_LEVEL; mad, acc, counters, wcnt at 0.
//  Price (in_valid, 00): delta=|price-avg|, avg=psum>>RING_LOG2.
//   - psum += price - ring[ptr]; ring[ptr]=price; ptr wraps mod depth.
//   - mad <= mad - (mad>>EMA_SH) + (delta>>EMA_SH), width DW.
//   - acc <= acc - (acc>>EMA_SH) + (sat8(delta)>>EMA_SH), 8 bit.
//  Volume (01): same ring/sum update on vring/vsum; cur_vol=volume.
//  Buy/sell (10/11): 8-bit count saturating at 255.
//  wcnt: WIN_LOG2-bit, increments every cycle, wraps. Terminal count TC = all ones.
//  At TC:
//   - buy_cnt <= sat((buy_cnt>>1) + buy_evt); same rule for sell.
//   - Frame built from pre-update register values; that cycle's sample updates state only.
//  Frame bytes:
//   [0] sat8(|newest-oldest| ring price)
//   [1] acc
//   [2] 128 + clamp(newest-avg, -127..+127)
//   [3] cur_vol < vavg/2 ? 0 : < vavg ? 64 : < 2vavg ? 128 : < 4vavg ? 192 : 255
//   [4] vavg[DW-1:DW-8]
//   [5] imbalance: both 0->128; buy 0->0; sell 0->255; b>s+s/2->192; s>b+b/2->64; else 128
//   [6] min(mad<<2, 255)
//   [7] sat8(buy_cnt+sell_cnt)
//   Division-free; vavg = vsum>>RING_LOG2. Compares use full-width, no truncation.
//  Handshake:
//   - Transfer when feat_valid & feat_ready; features stable while feat_valid & !feat_ready.
//   - At TC, load frame and set feat_valid if slot empty or transferring this cycle.
//   - Otherwise drop frame, keep old frame, pulse overrun next cycle.
//   - Transfer without load: feat_valid=0 next cycle.
//  Latency: first feat_valid high after 2^WIN_LOG2-th rising edge following reset release.
//  clear: state back to reset values, wcnt=0. Pending frame and feat_valid untouched; no frame on a clear cycle.
//  Async reset mid-window or mid-handshake: all outputs to reset values immediately.
// TESTING (WIN_LOG2=4, RING_LOG2=2, DW=12, EMA_SH=3, feat_ready=1 unless stated)
//  1. No samples after reset -> feat_valid at edge 16; bytes [0]=0,[2]=128,[3]=128,[5]=128,[7]=0.
//  2. Prices 100,100,100,140 -> byte0=40, byte2=128+30=158. Ring wraps on 5th price.
//  3. 300 buys, 0 sells -> buy_cnt saturates 255; byte5=255; byte7=255; next TC halves to 127.
//  4. feat_ready=0 for two windows -> first frame held bit-stable; overrun pulses once at 2nd TC.
//  5. Buy at TC with buy_cnt=10 -> buy_cnt=6; frame byte7 reflects pre-update count 10.
//  6. clear at cycle 8 with frame pending -> frame kept; next frame at cycle 8+16; all-reset stats.

Source files
------------

// File: rtl/feature_window_engine.sv
`default_nettype none
// ============================================================================
//  Module      : feature_window_engine
//  Description : Windowed market-feature extractor. Tracks price/volume rings,
//                EMA deviation stats and buy/sell pressure, and emits one
//                8-byte feature frame per window over a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module feature_window_engine #(
  parameter int DW        = 12,
  parameter int RING_LOG2 = 2,
  parameter int WIN_LOG2  = 8,
  parameter int EMA_SH    = 3,
  parameter int RST_LEVEL = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [1:0]    input_type,
  input  logic [DW-1:0] price_data,
  input  logic [DW-1:0] volume_data,
  input  logic          clear,
  output logic          feat_valid,
  input  logic          feat_ready,
  output logic [63:0]   features,
  output logic          overrun
);

  localparam int                    c_depth    = 1 << RING_LOG2;
  localparam int                    c_sw       = DW + RING_LOG2;
  localparam logic [DW-1:0]         c_rst_val  = DW'(RST_LEVEL);
  localparam logic [c_sw-1:0]       c_rst_sum  = c_sw'(RST_LEVEL) << RING_LOG2;
  localparam logic [DW-1:0]         c_sat8     = DW'(255);
  localparam logic [DW+1:0]         c_sat8_ext = (DW+2)'(255);
  localparam logic signed [DW+1:0]  c_tr_pos   = (DW+2)'(127);
  localparam logic signed [DW+1:0]  c_tr_neg   = -(DW+2)'(127);

  // Registered statistics state
  logic [DW-1:0]        r_pring [c_depth];
  logic [RING_LOG2-1:0] r_pptr;
  logic [c_sw-1:0]      r_psum;
  logic [DW-1:0]        r_vring [c_depth];
  logic [RING_LOG2-1:0] r_vptr;
  logic [c_sw-1:0]      r_vsum;
  logic [DW-1:0]        r_cur_vol;
  logic [DW-1:0]        r_mad;
  logic [7:0]           r_acc;
  logic [7:0]           r_buy;
  logic [7:0]           r_sell;
  logic [WIN_LOG2-1:0]  r_wcnt;

  // Sample decode and window timing
  logic w_is_price, w_is_vol, w_buy_evt, w_sell_evt;
  logic w_tc, w_emit, w_xfer;
  assign w_is_price = in_valid && (input_type == 2'b00);
  assign w_is_vol   = in_valid && (input_type == 2'b01);
  assign w_buy_evt  = in_valid && (input_type == 2'b10);
  assign w_sell_evt = in_valid && (input_type == 2'b11);
  assign w_tc       = &r_wcnt;
  assign w_emit     = w_tc && !clear;
  assign w_xfer     = feat_valid && feat_ready;

  // Ring averages (sum >> RING_LOG2) and price deviation
  logic [DW-1:0]        w_pavg, w_vavg, w_delta, w_mad_next;
  logic [7:0]           w_delta8, w_acc_next;
  logic [c_sw-1:0]      w_psum_next, w_vsum_next;
  logic [RING_LOG2-1:0] w_newest_idx;
  logic [DW-1:0]        w_newest, w_oldest, w_span;
  assign w_pavg       = r_psum[c_sw-1:RING_LOG2];
  assign w_vavg       = r_vsum[c_sw-1:RING_LOG2];
  assign w_delta      = (price_data >= w_pavg) ? (price_data - w_pavg) : (w_pavg - price_data);
  assign w_delta8     = (w_delta > c_sat8) ? 8'hFF : w_delta[7:0];
  assign w_mad_next   = r_mad - (r_mad >> EMA_SH) + (w_delta >> EMA_SH);
  assign w_acc_next   = r_acc - (r_acc >> EMA_SH) + (w_delta8 >> EMA_SH);
  assign w_psum_next  = r_psum + {{RING_LOG2{1'b0}}, price_data} - {{RING_LOG2{1'b0}}, r_pring[r_pptr]};
  assign w_vsum_next  = r_vsum + {{RING_LOG2{1'b0}}, volume_data} - {{RING_LOG2{1'b0}}, r_vring[r_vptr]};
  assign w_newest_idx = r_pptr - RING_LOG2'(1);
  assign w_newest     = r_pring[w_newest_idx];
  assign w_oldest     = r_pring[r_pptr];
  assign w_span       = (w_newest >= w_oldest) ? (w_newest - w_oldest) : (w_oldest - w_newest);

  // Buy/sell pressure: saturating count, halved with fresh event at window end
  logic [7:0] w_buy_next, w_sell_next;
  assign w_buy_next  = w_tc ? ({1'b0, r_buy[7:1]} + {7'b0, w_buy_evt})
                            : ((r_buy == 8'hFF) ? r_buy : r_buy + {7'b0, w_buy_evt});
  assign w_sell_next = w_tc ? ({1'b0, r_sell[7:1]} + {7'b0, w_sell_evt})
                            : ((r_sell == 8'hFF) ? r_sell : r_sell + {7'b0, w_sell_evt});

  // Frame assembly from current (pre-update) register values
  logic signed [DW+1:0] w_trend;
  logic [DW+1:0]        w_cv_ext, w_vhalf, w_v1, w_v2, w_v4, w_mad4;
  logic [8:0]           w_b9, w_s9, w_b15, w_s15, w_bs;
  logic [63:0]          w_frame;
  assign w_trend  = $signed({2'b00, w_newest}) - $signed({2'b00, w_pavg});
  assign w_cv_ext = {2'b00, r_cur_vol};
  assign w_vhalf  = {3'b000, w_vavg[DW-1:1]};
  assign w_v1     = {2'b00, w_vavg};
  assign w_v2     = {1'b0, w_vavg, 1'b0};
  assign w_v4     = {w_vavg, 2'b00};
  assign w_mad4   = {r_mad, 2'b00};
  assign w_b9     = {1'b0, r_buy};
  assign w_s9     = {1'b0, r_sell};
  assign w_b15    = w_b9 + {2'b00, r_buy[7:1]};
  assign w_s15    = w_s9 + {2'b00, r_sell[7:1]};
  assign w_bs     = w_b9 + w_s9;

  // Combine the eight feature bytes
  always_comb begin
    w_frame = '0;
    w_frame[7:0]   = (w_span > c_sat8) ? 8'hFF : w_span[7:0];
    w_frame[15:8]  = r_acc;
    if (w_trend > c_tr_pos)      w_frame[23:16] = 8'd255;
    else if (w_trend < c_tr_neg) w_frame[23:16] = 8'd1;
    else                         w_frame[23:16] = 8'd128 + w_trend[7:0];
    if (w_cv_ext < w_vhalf)      w_frame[31:24] = 8'd0;
    else if (w_cv_ext < w_v1)    w_frame[31:24] = 8'd64;
    else if (w_cv_ext < w_v2)    w_frame[31:24] = 8'd128;
    else if (w_cv_ext < w_v4)    w_frame[31:24] = 8'd192;
    else                         w_frame[31:24] = 8'd255;
    w_frame[39:32] = w_vavg[DW-1:DW-8];
    if (r_buy == 8'd0 && r_sell == 8'd0) w_frame[47:40] = 8'd128;
    else if (r_buy == 8'd0)              w_frame[47:40] = 8'd0;
    else if (r_sell == 8'd0)             w_frame[47:40] = 8'd255;
    else if (w_b9 > w_s15)               w_frame[47:40] = 8'd192;
    else if (w_s9 > w_b15)               w_frame[47:40] = 8'd64;
    else                                 w_frame[47:40] = 8'd128;
    w_frame[55:48] = (w_mad4 > c_sat8_ext) ? 8'hFF : w_mad4[7:0];
    w_frame[63:56] = w_bs[8] ? 8'hFF : w_bs[7:0];
  end

  // Output slot: load at window end if free or draining, otherwise drop and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_valid <= 1'b0;
      features   <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_emit && (!feat_valid || w_xfer)) begin
        features   <= w_frame;
        feat_valid <= 1'b1;
      end else begin
        if (w_xfer) feat_valid <= 1'b0;
        if (w_emit) overrun <= 1'b1;
      end
    end
  end

  // Statistics update; soft clear restores the reset picture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_depth; k++) begin
        r_pring[k] <= c_rst_val;
        r_vring[k] <= c_rst_val;
      end
      r_pptr    <= '0;
      r_vptr    <= '0;
      r_psum    <= c_rst_sum;
      r_vsum    <= c_rst_sum;
      r_cur_vol <= c_rst_val;
      r_mad     <= '0;
      r_acc     <= '0;
      r_buy     <= '0;
      r_sell    <= '0;
      r_wcnt    <= '0;
    end else if (clear) begin
      for (int k = 0; k < c_depth; k++) begin
        r_pring[k] <= c_rst_val;
        r_vring[k] <= c_rst_val;
      end
      r_pptr    <= '0;
      r_vptr    <= '0;
      r_psum    <= c_rst_sum;
      r_vsum    <= c_rst_sum;
      r_cur_vol <= c_rst_val;
      r_mad     <= '0;
      r_acc     <= '0;
      r_buy     <= '0;
      r_sell    <= '0;
      r_wcnt    <= '0;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_is_price) begin
        r_pring[r_pptr] <= price_data;
        r_pptr          <= r_pptr + 1'b1;
        r_psum          <= w_psum_next;
        r_mad           <= w_mad_next;
        r_acc           <= w_acc_next;
      end
      if (w_is_vol) begin
        r_vring[r_vptr] <= volume_data;
        r_vptr          <= r_vptr + 1'b1;
        r_vsum          <= w_vsum_next;
        r_cur_vol       <= volume_data;
      end
      r_buy  <= w_buy_next;
      r_sell <= w_sell_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_window_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feature_window_engine
//  Description : Self-checking bench for feature_window_engine. Two instances
//                (16-cycle and 512-cycle windows) share one stimulus stream and
//                are compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_window_engine;

  localparam int DW  = 12;
  localparam int RL  = 2;
  localparam int D   = 1 << RL;
  localparam int SH  = 3;
  localparam int RST = 100;
  localparam int WA  = 4;
  localparam int WB  = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    input_type = 2'b00;
  logic [DW-1:0] price_data = '0;
  logic [DW-1:0] volume_data = '0;
  logic          clear = 1'b0;
  logic          feat_ready = 1'b1;
  logic          fv_a, fv_b, ov_a, ov_b;
  logic [63:0]   ft_a, ft_b;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  feature_window_engine #(.DW(DW), .RING_LOG2(RL), .WIN_LOG2(WA), .EMA_SH(SH), .RST_LEVEL(RST)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .input_type(input_type),
    .price_data(price_data), .volume_data(volume_data), .clear(clear),
    .feat_valid(fv_a), .feat_ready(feat_ready), .features(ft_a), .overrun(ov_a));

  feature_window_engine #(.DW(DW), .RING_LOG2(RL), .WIN_LOG2(WB), .EMA_SH(SH), .RST_LEVEL(RST)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .input_type(input_type),
    .price_data(price_data), .volume_data(volume_data), .clear(clear),
    .feat_valid(fv_b), .feat_ready(feat_ready), .features(ft_b), .overrun(ov_b));

  // Free-running clock
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------
  int          hist [2][D];   // [0] oldest .. [D-1] newest
  int          vhist[2][D];
  int          cur_vol[2], mad[2], acc[2], buy[2], sell[2], wcnt[2];
  bit          m_fv[2], m_ov[2];
  logic [63:0] m_ft[2];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic [63:0] model_frame(input int i);
    int avg, vavg, newest, oldest, t, b, s, cv;
    logic [7:0] by [8];
    avg = 0; vavg = 0;
    for (int k = 0; k < D; k++) begin
      avg  += hist[i][k];
      vavg += vhist[i][k];
    end
    avg = avg / D; vavg = vavg / D;
    newest = hist[i][D-1]; oldest = hist[i][0];
    by[0] = 8'(imin(iabs(newest - oldest), 255));
    by[1] = 8'(acc[i]);
    t = newest - avg;
    if (t > 127) t = 127;
    if (t < -127) t = -127;
    by[2] = 8'(128 + t);
    cv = cur_vol[i];
    if (cv < vavg / 2)      by[3] = 8'd0;
    else if (cv < vavg)     by[3] = 8'd64;
    else if (cv < 2 * vavg) by[3] = 8'd128;
    else if (cv < 4 * vavg) by[3] = 8'd192;
    else                    by[3] = 8'd255;
    by[4] = 8'(vavg / (1 << (DW - 8)));
    b = buy[i]; s = sell[i];
    if (b == 0 && s == 0)   by[5] = 8'd128;
    else if (b == 0)        by[5] = 8'd0;
    else if (s == 0)        by[5] = 8'd255;
    else if (b > s + s / 2) by[5] = 8'd192;
    else if (s > b + b / 2) by[5] = 8'd64;
    else                    by[5] = 8'd128;
    by[6] = 8'(imin(mad[i] * 4, 255));
    by[7] = 8'(imin(b + s, 255));
    return {by[7], by[6], by[5], by[4], by[3], by[2], by[1], by[0]};
  endfunction

  task automatic model_clear(input int i);
    for (int k = 0; k < D; k++) begin
      hist[i][k]  = RST;
      vhist[i][k] = RST;
    end
    cur_vol[i] = RST; mad[i] = 0; acc[i] = 0; buy[i] = 0; sell[i] = 0; wcnt[i] = 0;
  endtask

  task automatic model_step(input int i, input int wl);
    logic [63:0] fr;
    bit tc, emit, xfer;
    int avg, delta, eb, es;
    fr   = model_frame(i);
    tc   = (wcnt[i] == (1 << wl) - 1);
    emit = tc && !clear;
    xfer = m_fv[i] && feat_ready;
    m_ov[i] = 1'b0;
    if (emit) begin
      if (!m_fv[i] || xfer) begin
        m_ft[i] = fr;
        m_fv[i] = 1'b1;
      end else begin
        m_ov[i] = 1'b1;
      end
    end else if (xfer) begin
      m_fv[i] = 1'b0;
    end
    if (clear) begin
      model_clear(i);
    end else begin
      wcnt[i] = (wcnt[i] + 1) % (1 << wl);
      eb = (in_valid && input_type == 2'b10) ? 1 : 0;
      es = (in_valid && input_type == 2'b11) ? 1 : 0;
      if (in_valid && input_type == 2'b00) begin
        avg = 0;
        for (int k = 0; k < D; k++) avg += hist[i][k];
        avg   = avg / D;
        delta = iabs(int'(price_data) - avg);
        mad[i] = (mad[i] - mad[i] / (1 << SH) + delta / (1 << SH)) % (1 << DW);
        acc[i] = (acc[i] - acc[i] / (1 << SH) + imin(delta, 255) / (1 << SH)) % 256;
        for (int k = 0; k < D - 1; k++) hist[i][k] = hist[i][k+1];
        hist[i][D-1] = int'(price_data);
      end
      if (in_valid && input_type == 2'b01) begin
        for (int k = 0; k < D - 1; k++) vhist[i][k] = vhist[i][k+1];
        vhist[i][D-1] = int'(volume_data);
        cur_vol[i] = int'(volume_data);
      end
      if (tc) begin
        buy[i]  = imin(buy[i] / 2 + eb, 255);
        sell[i] = imin(sell[i] / 2 + es, 255);
      end else begin
        buy[i]  = imin(buy[i] + eb, 255);
        sell[i] = imin(sell[i] + es, 255);
      end
    end
  endtask

  // Model advances on the same edges as the DUTs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        model_clear(i);
        m_fv[i] = 1'b0; m_ov[i] = 1'b0; m_ft[i] = '0;
      end
    end else begin
      model_step(0, WA);
      model_step(1, WB);
    end
  end

  // ---------------- checking helpers ----------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%h expected=%h", nm, ecount, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("fv_a", {63'd0, fv_a}, {63'd0, m_fv[0]});
    chk("ft_a", ft_a, m_ft[0]);
    chk("ov_a", {63'd0, ov_a}, {63'd0, m_ov[0]});
    chk("fv_b", {63'd0, fv_b}, {63'd0, m_fv[1]});
    chk("ft_b", ft_b, m_ft[1]);
    chk("ov_b", {63'd0, ov_b}, {63'd0, m_ov[1]});
  endtask

  task automatic step(input bit v, input logic [1:0] t, input int p, input int vol,
                      input bit clr, input bit rdy);
    in_valid    = v;
    input_type  = t;
    price_data  = DW'(p);
    volume_data = DW'(vol);
    clear       = clr;
    feat_ready  = rdy;
    @(negedge clk);
    ecount++;
    compare_all();
  endtask

  task automatic run_to(input int n, input bit rdy);
    while (ecount < n) step(1'b0, 2'b00, 0, 0, 1'b0, rdy);
  endtask

  // ---------------- stimulus -------------------------------------------------
  initial begin
    bit stall;
    bit v;
    int p, vol;
    stall = 1'b0;
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    chk("rst_fv", {63'd0, fv_a}, 64'd0);
    chk("rst_ft", ft_a, 64'd0);
    chk("rst_ov", {63'd0, ov_a}, 64'd0);
    rst_n  = 1'b1;
    ecount = 0;

    // Idle window: first frame after the 16th edge
    run_to(15, 1'b1);
    chk("t1_pre", {63'd0, fv_a}, 64'd0);
    run_to(16, 1'b1);
    chk("t1_valid", {63'd0, fv_a}, 64'd1);
    chk("t1_frame", ft_a, 64'h0000_8006_8080_0000);

    // Price ramp
    step(1'b1, 2'b00, 100, 0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 100, 0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 100, 0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 140, 0, 1'b0, 1'b1);
    run_to(32, 1'b1);
    chk("t2_span", {56'd0, ft_a[7:0]}, 64'd40);
    chk("t2_trend", {56'd0, ft_a[23:16]}, 64'd158);
    chk("t2_acc", {56'd0, ft_a[15:8]}, 64'd5);
    chk("t2_mad", {56'd0, ft_a[55:48]}, 64'd20);

    // Ten buys, then a buy on the terminal-count cycle
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 0, 0, 1'b0, 1'b1);
    run_to(47, 1'b1);
    step(1'b1, 2'b10, 0, 0, 1'b0, 1'b1);
    chk("t5_pre_cnt", {56'd0, ft_a[63:56]}, 64'd10);
    chk("t5_imbal", {56'd0, ft_a[47:40]}, 64'd255);

    // Backpressure across two windows
    run_to(63, 1'b1);
    run_to(64, 1'b0);
    chk("t5_post_cnt", {56'd0, ft_a[63:56]}, 64'd6);
    chk("t4_frame", ft_a, 64'h0614_FF06_809E_0528);
    run_to(80, 1'b0);
    chk("t4_hold", ft_a, 64'h0614_FF06_809E_0528);
    chk("t4_ovr", {63'd0, ov_a}, 64'd1);
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    chk("t4_ovr_end", {63'd0, ov_a}, 64'd0);

    // Soft clear with a frame pending
    run_to(95, 1'b1);
    run_to(103, 1'b0);
    step(1'b0, 2'b00, 0, 0, 1'b1, 1'b0);
    chk("t6_keep_v", {63'd0, fv_a}, 64'd1);
    chk("t6_keep_ft", ft_a, 64'h0114_FF06_809E_0528);
    run_to(109, 1'b0);
    run_to(112, 1'b1);
    chk("t6_noframe", {63'd0, fv_a}, 64'd0);
    run_to(119, 1'b1);
    chk("t6_pre", {63'd0, fv_a}, 64'd0);
    run_to(120, 1'b1);
    chk("t6_valid", {63'd0, fv_a}, 64'd1);
    chk("t6_frame", ft_a, 64'h0000_8006_8080_0000);

    // Long window instance: 300 buys saturate the counter
    for (int k = 0; k < 300; k++) step(1'b1, 2'b10, 0, 0, 1'b0, 1'b1);
    run_to(616, 1'b1);
    chk("t3_cnt", {56'd0, ft_b[63:56]}, 64'd255);
    chk("t3_imbal", {56'd0, ft_b[47:40]}, 64'd255);
    run_to(1128, 1'b1);
    chk("t3_halved", {56'd0, ft_b[63:56]}, 64'd127);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fv", {63'd0, fv_a}, 64'd0);
    chk("arst_ft_a", ft_a, 64'd0);
    chk("arst_ft_b", ft_b, 64'd0);
    chk("arst_ov", {63'd0, ov_a}, 64'd0);
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Randomised traffic with stalls and occasional clears
    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 16 == 0) stall = ~stall;
      v   = ($urandom % 4) != 0;
      p   = ($urandom % 2) ? int'($urandom_range(1900, 2100)) : int'($urandom_range(0, 4095));
      vol = ($urandom % 2) ? int'($urandom_range(50, 400)) : int'($urandom_range(0, 4095));
      step(v, 2'($urandom % 4), p, vol, ($urandom % 150) == 0,
           stall ? 1'b0 : (($urandom % 4) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
